// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the parametrised UART transceiver:
//   - uart_state_e : 3-bit state encoding used by both the TX and RX FSMs
//   - PAR_*        : parity mode codes matching the PARITY parameter values
//   - UART_OP_WRITE: UARTOp code that requests a transmit
//   - parity_bit() : parity bit for a (zero-extended) data word
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_state_e;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_ODD  = 2'd1;
    localparam logic [1:0] PAR_EVEN = 2'd2;

    localparam logic [1:0] UART_OP_WRITE = 2'b10;

    // Unused upper bits of i_data must be zero so they do not disturb the XOR.
    function automatic logic parity_bit(input logic [8:0] i_data, input logic [1:0] i_mode);
        logic w_even;
        w_even = ^i_data;
        if (i_mode == PAR_ODD) begin
            return ~w_even;
        end else begin
            return w_even;
        end
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
// Free-running bit-period counter. Counts 0 .. BIT_CLKS-1 and wraps; held at 0
// while i_clear is high, so the first cycle after clear is count 0 of a bit.
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_clear        : hold the count at zero
//   o_mid_tick     : count == (BIT_CLKS-1)/2 (mid-bit sample point)
//   o_end_tick     : count == BIT_CLKS-1 (last cycle of the bit)
// -----------------------------------------------------------------------------
module uart_bit_timer #(
    parameter int BIT_CLKS = 10
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    output logic o_mid_tick,
    output logic o_end_tick
);

    localparam logic [15:0] MID_COUNT  = 16'((BIT_CLKS - 1) / 2);
    localparam logic [15:0] LAST_COUNT = 16'(BIT_CLKS - 1);

    logic [15:0] r_count;

    // Bit-period counter with clear and wrap at the end of each bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= 16'd0;
        end else if (i_clear) begin
            r_count <= 16'd0;
        end else if (r_count == LAST_COUNT) begin
            r_count <= 16'd0;
        end else begin
            r_count <= r_count + 16'd1;
        end
    end

    assign o_mid_tick = (r_count == MID_COUNT);
    assign o_end_tick = (r_count == LAST_COUNT);

endmodule

// File: rtl/uart_param.sv
// -----------------------------------------------------------------------------
// uart_param
// Full-duplex UART with compile-time data width (5..9), parity (0 none,
// 1 odd, 2 even) and 1 or 2 stop bits. TX and RX run independently.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   UARTOp, WriteData : 2'b10 starts a transmit of WriteData when TxBusy is 0
//   ReadData          : last received payload, zero-extended to 32 bits
//   DataReadFromLine  : one-cycle strobe when ReadData/error flags update
//   ParityError       : last frame's parity mismatched (0 with no parity)
//   FrameError        : last frame's first stop bit sampled low
//   TxBusy            : transmitter occupied; writes are dropped
//   rx, tx            : serial pins (rx asynchronous, tx idles high)
// -----------------------------------------------------------------------------
module uart_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQUENCY = 50_000_000,
    parameter int BAUD_RATE     = 9600,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           UARTOp,
    input  logic [DATA_BITS-1:0] WriteData,
    output logic [31:0]          ReadData,
    output logic                 DataReadFromLine,
    output logic                 ParityError,
    output logic                 FrameError,
    output logic                 TxBusy,
    input  logic                 rx,
    output logic                 tx
);

    localparam int         BIT_CLKS      = CLK_FREQUENCY / BAUD_RATE;
    localparam logic [1:0] PAR_MODE      = 2'(PARITY);
    localparam bit         HAS_PARITY    = (PARITY != 0);
    localparam logic [3:0] LAST_DATA_IDX = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP_IDX = 4'(STOP_BITS - 1);

    if (BIT_CLKS > 65535 || BIT_CLKS < 4) begin : g_bad_bit_clks
        $error("uart_param: BIT_CLKS must be within 4..65535");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_frame
        $error("uart_param: unsupported frame format");
    end

    // ------------------------------------------------------------------ TX
    uart_state_e          r_tx_state,  w_tx_state_next;
    logic [DATA_BITS-1:0] r_tx_shift,  w_tx_shift_next;
    logic [3:0]           r_tx_bitcnt, w_tx_bitcnt_next;
    logic                 r_tx_par,    w_tx_par_next;
    logic                 r_tx;
    logic                 r_tx_busy;
    logic                 w_tx_end;
    logic                 w_tx_mid_unused;

    uart_bit_timer #(.BIT_CLKS(BIT_CLKS)) u_tx_timer (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_clear    (r_tx_state == ST_IDLE),
        .o_mid_tick (w_tx_mid_unused),
        .o_end_tick (w_tx_end)
    );

    // TX FSM state and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state  <= ST_IDLE;
            r_tx_shift  <= '0;
            r_tx_bitcnt <= 4'd0;
            r_tx_par    <= 1'b0;
        end else begin
            r_tx_state  <= w_tx_state_next;
            r_tx_shift  <= w_tx_shift_next;
            r_tx_bitcnt <= w_tx_bitcnt_next;
            r_tx_par    <= w_tx_par_next;
        end
    end

    // TX next state: the shift register advances at the end of each data bit;
    // r_tx_bitcnt indexes data bits, then stop bits.
    always_comb begin
        w_tx_state_next  = r_tx_state;
        w_tx_shift_next  = r_tx_shift;
        w_tx_bitcnt_next = r_tx_bitcnt;
        w_tx_par_next    = r_tx_par;
        case (r_tx_state)
            ST_IDLE: begin
                if (UARTOp == UART_OP_WRITE && !r_tx_busy) begin
                    w_tx_state_next  = ST_START;
                    w_tx_shift_next  = WriteData;
                    w_tx_bitcnt_next = 4'd0;
                    w_tx_par_next    = parity_bit(9'(WriteData), PAR_MODE);
                end else begin
                    w_tx_state_next = ST_IDLE;
                end
            end
            ST_START: begin
                if (w_tx_end) begin
                    w_tx_state_next  = ST_DATA;
                    w_tx_bitcnt_next = 4'd0;
                end else begin
                    w_tx_state_next = ST_START;
                end
            end
            ST_DATA: begin
                if (w_tx_end) begin
                    w_tx_shift_next = r_tx_shift >> 1;
                    if (r_tx_bitcnt == LAST_DATA_IDX) begin
                        w_tx_bitcnt_next = 4'd0;
                        if (HAS_PARITY) begin
                            w_tx_state_next = ST_PARITY;
                        end else begin
                            w_tx_state_next = ST_STOP;
                        end
                    end else begin
                        w_tx_bitcnt_next = r_tx_bitcnt + 4'd1;
                    end
                end else begin
                    w_tx_state_next = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (w_tx_end) begin
                    w_tx_state_next  = ST_STOP;
                    w_tx_bitcnt_next = 4'd0;
                end else begin
                    w_tx_state_next = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (w_tx_end) begin
                    if (r_tx_bitcnt == LAST_STOP_IDX) begin
                        w_tx_state_next  = ST_IDLE;
                        w_tx_bitcnt_next = 4'd0;
                    end else begin
                        w_tx_bitcnt_next = r_tx_bitcnt + 4'd1;
                    end
                end else begin
                    w_tx_state_next = ST_STOP;
                end
            end
            default: begin
                w_tx_state_next  = ST_IDLE;
                w_tx_bitcnt_next = 4'd0;
            end
        endcase
    end

    // Registered line and busy outputs; they trail the FSM by one cycle, so
    // every bit on tx still lasts exactly BIT_CLKS cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx      <= 1'b1;
            r_tx_busy <= 1'b0;
        end else begin
            r_tx_busy <= (r_tx_state != ST_IDLE);
            case (r_tx_state)
                ST_START:  r_tx <= 1'b0;
                ST_DATA:   r_tx <= r_tx_shift[0];
                ST_PARITY: r_tx <= r_tx_par;
                default:   r_tx <= 1'b1;
            endcase
        end
    end

    assign tx     = r_tx;
    assign TxBusy = r_tx_busy;

    // ------------------------------------------------------------------ RX
    logic [1:0]           r_rx_sync;
    logic                 w_rx_in;
    uart_state_e          r_rx_state,  w_rx_state_next;
    logic [DATA_BITS-1:0] r_rx_shift,  w_rx_shift_next;
    logic [3:0]           r_rx_bitcnt, w_rx_bitcnt_next;
    logic                 r_rx_perr,   w_rx_perr_next;
    logic                 w_rx_strobe;
    logic                 w_rx_mid;
    logic                 w_rx_end;
    logic                 r_strobe;
    logic [31:0]          r_read_data;
    logic                 r_parity_error;
    logic                 r_frame_error;

    assign w_rx_in = r_rx_sync[1];

    uart_bit_timer #(.BIT_CLKS(BIT_CLKS)) u_rx_timer (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_clear    (r_rx_state == ST_IDLE),
        .o_mid_tick (w_rx_mid),
        .o_end_tick (w_rx_end)
    );

    // Two-flop synchronizer for the asynchronous rx pin; resets to idle-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_sync <= 2'b11;
        end else begin
            r_rx_sync <= {r_rx_sync[0], rx};
        end
    end

    // RX FSM state and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state  <= ST_IDLE;
            r_rx_shift  <= '0;
            r_rx_bitcnt <= 4'd0;
            r_rx_perr   <= 1'b0;
        end else begin
            r_rx_state  <= w_rx_state_next;
            r_rx_shift  <= w_rx_shift_next;
            r_rx_bitcnt <= w_rx_bitcnt_next;
            r_rx_perr   <= w_rx_perr_next;
        end
    end

    // RX next state: bits are sampled at mid-bit, states advance at bit end.
    // Data enters at the MSB so the first (LSB) bit ends up in bit 0.
    always_comb begin
        w_rx_state_next  = r_rx_state;
        w_rx_shift_next  = r_rx_shift;
        w_rx_bitcnt_next = r_rx_bitcnt;
        w_rx_perr_next   = r_rx_perr;
        w_rx_strobe      = 1'b0;
        case (r_rx_state)
            ST_IDLE: begin
                w_rx_bitcnt_next = 4'd0;
                w_rx_perr_next   = 1'b0;
                if (!w_rx_in) begin
                    w_rx_state_next = ST_START;
                end else begin
                    w_rx_state_next = ST_IDLE;
                end
            end
            ST_START: begin
                if (w_rx_mid && w_rx_in) begin
                    // Start bit gone high by mid-bit: treat as a glitch.
                    w_rx_state_next = ST_IDLE;
                end else if (w_rx_end) begin
                    w_rx_state_next  = ST_DATA;
                    w_rx_bitcnt_next = 4'd0;
                end else begin
                    w_rx_state_next = ST_START;
                end
            end
            ST_DATA: begin
                if (w_rx_mid) begin
                    w_rx_shift_next = {w_rx_in, r_rx_shift[DATA_BITS-1:1]};
                end else begin
                    w_rx_shift_next = r_rx_shift;
                end
                if (w_rx_end) begin
                    if (r_rx_bitcnt == LAST_DATA_IDX) begin
                        w_rx_bitcnt_next = 4'd0;
                        if (HAS_PARITY) begin
                            w_rx_state_next = ST_PARITY;
                        end else begin
                            w_rx_state_next = ST_STOP;
                        end
                    end else begin
                        w_rx_bitcnt_next = r_rx_bitcnt + 4'd1;
                    end
                end else begin
                    w_rx_state_next = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (w_rx_mid) begin
                    w_rx_perr_next = (w_rx_in != parity_bit(9'(r_rx_shift), PAR_MODE));
                end else if (w_rx_end) begin
                    w_rx_state_next = ST_STOP;
                end else begin
                    w_rx_state_next = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (w_rx_mid) begin
                    // Deliver on the first stop bit; a low stop bit is a
                    // framing error and may be the start of a line break.
                    w_rx_strobe = 1'b1;
                    if (w_rx_in) begin
                        w_rx_state_next = ST_IDLE;
                    end else begin
                        w_rx_state_next = ST_BREAK;
                    end
                end else begin
                    w_rx_state_next = ST_STOP;
                end
            end
            ST_BREAK: begin
                if (w_rx_in) begin
                    w_rx_state_next = ST_IDLE;
                end else begin
                    w_rx_state_next = ST_BREAK;
                end
            end
            default: begin
                w_rx_state_next = ST_IDLE;
            end
        endcase
    end

    // Receive outputs: loaded together on the strobe, held until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_strobe       <= 1'b0;
            r_read_data    <= 32'd0;
            r_parity_error <= 1'b0;
            r_frame_error  <= 1'b0;
        end else begin
            r_strobe <= w_rx_strobe;
            if (w_rx_strobe) begin
                r_read_data    <= 32'(r_rx_shift);
                r_parity_error <= r_rx_perr;
                r_frame_error  <= ~w_rx_in;
            end
        end
    end

    assign ReadData         = r_read_data;
    assign DataReadFromLine = r_strobe;
    assign ParityError      = r_parity_error;
    assign FrameError       = r_frame_error;

endmodule

// File: tb/tb_uart_param.sv
// -----------------------------------------------------------------------------
// tb_uart_param
// Directed bench with BIT_CLKS = 10. Three instances:
//   u_a : 8N1   (TX frame timing, reset mid-TX)
//   u_b : 7E2   (TX with parity, two stop bits, dropped write)
//   u_c : 8E1   (RX: good frame, parity error, framing error/break, glitch,
//                reset mid-RX)
// -----------------------------------------------------------------------------
module tb_uart_param;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic [1:0]  a_op;   logic [7:0] a_wd;  logic [31:0] a_rd;
    logic        a_str, a_pe, a_fe, a_busy, a_rx, a_tx;
    logic [1:0]  b_op;   logic [6:0] b_wd;  logic [31:0] b_rd;
    logic        b_str, b_pe, b_fe, b_busy, b_rx, b_tx;
    logic [1:0]  c_op;   logic [7:0] c_wd;  logic [31:0] c_rd;
    logic        c_str, c_pe, c_fe, c_busy, c_rx, c_tx;

    uart_param #(.CLK_FREQUENCY(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                 .PARITY(0), .STOP_BITS(1)) u_a (
        .clk(clk), .rst(rst), .UARTOp(a_op), .WriteData(a_wd), .ReadData(a_rd),
        .DataReadFromLine(a_str), .ParityError(a_pe), .FrameError(a_fe),
        .TxBusy(a_busy), .rx(a_rx), .tx(a_tx));

    uart_param #(.CLK_FREQUENCY(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7),
                 .PARITY(2), .STOP_BITS(2)) u_b (
        .clk(clk), .rst(rst), .UARTOp(b_op), .WriteData(b_wd), .ReadData(b_rd),
        .DataReadFromLine(b_str), .ParityError(b_pe), .FrameError(b_fe),
        .TxBusy(b_busy), .rx(b_rx), .tx(b_tx));

    uart_param #(.CLK_FREQUENCY(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                 .PARITY(2), .STOP_BITS(1)) u_c (
        .clk(clk), .rst(rst), .UARTOp(c_op), .WriteData(c_wd), .ReadData(c_rd),
        .DataReadFromLine(c_str), .ParityError(c_pe), .FrameError(c_fe),
        .TxBusy(c_busy), .rx(c_rx), .tx(c_tx));

    int n_checks = 0;
    int n_fail   = 0;
    int strobe_cnt = 0;
    int base;

    // Count receive strobes of u_c (a two-cycle strobe counts twice).
    always @(posedge clk) begin
        if (c_str) strobe_cnt <= strobe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rx_bits(input logic b, input int n);
        c_rx = b;
        repeat (n) step();
    endtask

    // 8E1 frame onto u_c's rx; par_flip inverts the parity bit.
    task automatic rx_frame(input logic [7:0] d, input logic par_flip, input logic stop_v);
        rx_bits(1'b0, 10);
        for (int i = 0; i < 8; i++) rx_bits(d[i], 10);
        rx_bits((^d) ^ par_flip, 10);
        rx_bits(stop_v, 10);
    endtask

    // Transmit d on u_a and check every cycle of the 8N1 frame.
    task automatic tx_a(input logic [7:0] d);
        logic [9:0] frame;
        frame = {1'b1, d, 1'b0};
        a_op = 2'b10; a_wd = d;
        step();
        a_op = 2'b00;
        step();
        for (int c = 0; c < 100; c++) begin
            check("a_tx_bit", 32'(a_tx), 32'(frame[c / 10]));
            check("a_busy_high", 32'(a_busy), 32'd1);
            step();
        end
        check("a_busy_fall", 32'(a_busy), 32'd0);
        check("a_tx_idle", 32'(a_tx), 32'd1);
    endtask

    initial begin
        logic [10:0] frame_b;
        rst = 1'b1;
        a_op = 2'b00; a_wd = 8'h00; a_rx = 1'b1;
        b_op = 2'b00; b_wd = 7'h00; b_rx = 1'b1;
        c_op = 2'b00; c_wd = 8'h00; c_rx = 1'b1;
        repeat (3) step();

        // Reset state
        check("rst_a_tx", 32'(a_tx), 32'd1);
        check("rst_a_busy", 32'(a_busy), 32'd0);
        check("rst_b_tx", 32'(b_tx), 32'd1);
        check("rst_c_rd", c_rd, 32'd0);
        check("rst_c_str", 32'(c_str), 32'd0);
        check("rst_c_pe", 32'(c_pe), 32'd0);
        check("rst_c_fe", 32'(c_fe), 32'd0);
        rst = 1'b0;
        repeat (2) step();

        // 8N1 TX of 0xA5
        tx_a(8'hA5);
        repeat (5) step();

        // 7E2 TX of 0x41 with a write dropped mid-frame
        frame_b = {2'b11, 1'b0, 7'h41, 1'b0};
        b_op = 2'b10; b_wd = 7'h41;
        step();
        b_op = 2'b00;
        step();
        for (int c = 0; c < 110; c++) begin
            if (c == 50) begin
                b_op = 2'b10; b_wd = 7'h7F;
            end else begin
                b_op = 2'b00;
            end
            check("b_tx_bit", 32'(b_tx), 32'(frame_b[c / 10]));
            check("b_busy_high", 32'(b_busy), 32'd1);
            step();
        end
        check("b_busy_fall", 32'(b_busy), 32'd0);
        for (int c = 0; c < 20; c++) begin
            check("b_drop_busy", 32'(b_busy), 32'd0);
            check("b_drop_tx", 32'(b_tx), 32'd1);
            step();
        end

        // RX 8E1 0x3C, correct parity
        base = strobe_cnt;
        rx_frame(8'h3C, 1'b0, 1'b1);
        rx_bits(1'b1, 20);
        check("rx_good_strobes", 32'(strobe_cnt - base), 32'd1);
        check("rx_good_data", c_rd, 32'h0000003C);
        check("rx_good_pe", 32'(c_pe), 32'd0);
        check("rx_good_fe", 32'(c_fe), 32'd0);

        // RX 0x3C, flipped parity
        base = strobe_cnt;
        rx_frame(8'h3C, 1'b1, 1'b1);
        rx_bits(1'b1, 20);
        check("rx_perr_strobes", 32'(strobe_cnt - base), 32'd1);
        check("rx_perr_data", c_rd, 32'h0000003C);
        check("rx_perr_pe", 32'(c_pe), 32'd1);
        check("rx_perr_fe", 32'(c_fe), 32'd0);

        // Framing error, then line held low (break)
        base = strobe_cnt;
        rx_frame(8'h0F, 1'b0, 1'b0);
        rx_bits(1'b0, 30);
        check("rx_ferr_strobes", 32'(strobe_cnt - base), 32'd1);
        check("rx_ferr_fe", 32'(c_fe), 32'd1);
        check("rx_ferr_pe", 32'(c_pe), 32'd0);
        check("rx_ferr_data", c_rd, 32'h0000000F);
        rx_bits(1'b1, 20);
        check("rx_break_nostrobe", 32'(strobe_cnt - base), 32'd1);
        base = strobe_cnt;
        rx_frame(8'h55, 1'b0, 1'b1);
        rx_bits(1'b1, 20);
        check("rx_after_break_strobes", 32'(strobe_cnt - base), 32'd1);
        check("rx_after_break_data", c_rd, 32'h00000055);
        check("rx_after_break_fe", 32'(c_fe), 32'd0);
        check("rx_after_break_pe", 32'(c_pe), 32'd0);

        // 3-cycle glitch: no strobe; a frame 8 cycles later is received intact
        base = strobe_cnt;
        rx_bits(1'b0, 3);
        rx_bits(1'b1, 30);
        check("glitch_nostrobe", 32'(strobe_cnt - base), 32'd0);
        rx_bits(1'b0, 3);
        rx_bits(1'b1, 5);
        rx_frame(8'hC3, 1'b0, 1'b1);
        rx_bits(1'b1, 20);
        check("glitch_frame_strobes", 32'(strobe_cnt - base), 32'd1);
        check("glitch_frame_data", c_rd, 32'h000000C3);
        check("glitch_frame_pe", 32'(c_pe), 32'd0);

        // Reset mid-TX (u_a sending 0x00) and mid-RX (u_c inside a frame)
        base = strobe_cnt;
        a_op = 2'b10; a_wd = 8'h00; c_rx = 1'b0;
        step();
        a_op = 2'b00;
        repeat (25) step();
        check("pre_rst_a_tx", 32'(a_tx), 32'd0);
        check("pre_rst_a_busy", 32'(a_busy), 32'd1);
        c_rx = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_a_tx", 32'(a_tx), 32'd1);
        check("rst_mid_a_busy", 32'(a_busy), 32'd0);
        check("rst_mid_c_str", 32'(c_str), 32'd0);
        check("rst_mid_c_rd", c_rd, 32'd0);
        repeat (30) step();
        check("rst_mid_nostrobe", 32'(strobe_cnt - base), 32'd0);
        check("rst_mid_a_tx_idle", 32'(a_tx), 32'd1);
        tx_a(8'h3C);
        base = strobe_cnt;
        rx_frame(8'h5A, 1'b0, 1'b1);
        rx_bits(1'b1, 20);
        check("post_rst_strobes", 32'(strobe_cnt - base), 32'd1);
        check("post_rst_data", c_rd, 32'h0000005A);
        check("a_pe_never", 32'(a_pe), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
